// File: rtl/seq_divider_3x3.sv
// seq_divider_3x3: iterative restoring divider, one quotient bit per clock.
// Divides a 2*WIDTH-bit unsigned dividend by a WIDTH-bit unsigned divisor,
// with valid/ready handshakes on both the operand and the result side.
// A zero divisor skips the iteration and returns all-ones with div_by_zero set.
// Optional build macro MULT_CHECK_EN adds a multiply-back self check on chk_err.
module seq_divider_3x3 #(
  parameter int WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero,
  output logic                 chk_err
);

  localparam int CW = $clog2(2*WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(2*WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  // quo_q starts out holding the dividend; its MSB feeds the partial
  // remainder each step while the new quotient bit enters at the LSB.
  logic [2*WIDTH-1:0] quo_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   dvs_q;
  logic [CW-1:0]      count;
  logic               dbz_q;

  logic               accept;
  logic [WIDTH:0]     trial;
  logic               fits;
  logic [WIDTH-1:0]   diff;

  assign accept = in_valid && in_ready;

  // Partial remainder is WIDTH+1 bits wide only during the trial; when the
  // divisor fits, the difference is below the divisor and fits WIDTH bits.
  assign trial = {rem_q, quo_q[2*WIDTH-1]};
  assign fits  = (trial >= {1'b0, dvs_q});
  assign diff  = trial[WIDTH-1:0] - dvs_q;

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and handshake outputs
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) begin
          next_state = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (count == CNT_LAST) begin
          next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand capture and one restoring-division step per CALC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      count <= '0;
      dbz_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dvs_q <= divisor;
            if (divisor != '0) begin
              quo_q <= dividend;
              rem_q <= '0;
              count <= CNT_INIT;
              dbz_q <= 1'b0;
            end else begin
              quo_q <= '1;
              rem_q <= dividend[WIDTH-1:0];
              count <= '0;
              dbz_q <= 1'b1;
            end
          end
        end
        CALC: begin
          rem_q <= fits ? diff : trial[WIDTH-1:0];
          quo_q <= {quo_q[2*WIDTH-2:0], fits};
          count <= count - CNT_LAST;
        end
        default: begin
        end
      endcase
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

`ifdef MULT_CHECK_EN
  logic [2*WIDTH-1:0] dvd_q;
  logic [3*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] recon;

  // Keep the original dividend, since quo_q is consumed by the iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q <= '0;
    end else if (accept) begin
      dvd_q <= dividend;
    end
  end

  // Multiply the result back and compare against the captured dividend
  always_comb begin
    prod    = {{WIDTH{1'b0}}, quo_q} * {{(2*WIDTH){1'b0}}, dvs_q};
    recon   = prod[2*WIDTH-1:0] + {{WIDTH{1'b0}}, rem_q};
    chk_err = (state == DONE) && !dbz_q && (recon != dvd_q);
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider_3x3.sv
// tb_seq_divider_3x3: directed and exhaustive checks of seq_divider_3x3,
// with expected results queued at issue and compared when the result appears.
module tb_seq_divider_3x3;

  localparam int WIDTH = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] dividend;
  logic [WIDTH-1:0]   divisor;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] quotient;
  logic [WIDTH-1:0]   remainder;
  logic               div_by_zero;
  logic               chk_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;

  typedef struct packed {
    logic [2*WIDTH-1:0] q;
    logic [WIDTH-1:0]   r;
    logic               dbz;
    logic [7:0]         lat;
  } exp_t;

  exp_t sb[$];

  seq_divider_3x3 #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .chk_err     (chk_err)
  );

  always #5 clk = ~clk;

  // Free-running edge counter used to measure result latency
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offer one operation, wait for acceptance and queue the reference result
  task automatic applyStimulus(input logic [2*WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    accept_cyc = cyc;
    if (dvs == '0) begin
      e.q   = '1;
      e.r   = dvd[WIDTH-1:0];
      e.dbz = 1'b1;
      e.lat = 8'd0;
    end else begin
      e.q   = dvd / dvs;
      e.r   = WIDTH'(dvd % dvs);
      e.dbz = 1'b0;
      e.lat = 8'(2*WIDTH);
    end
    sb.push_back(e);
  endtask

  // Wait for a result, compare it, optionally stall, then transfer it.
  // Latency counts edges after the accepting edge: a zero divisor shows
  // out_valid right after the accepting edge itself.
  task automatic checkOutput(input string tag, input int hold);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_lat"}, cyc - accept_cyc, {24'd0, e.lat});
      check({tag, "_q"}, {26'd0, quotient}, {26'd0, e.q});
      check({tag, "_r"}, {29'd0, remainder}, {29'd0, e.r});
      check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
      check({tag, "_chk"}, {31'd0, chk_err}, 32'd0);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_hold_q"}, {26'd0, quotient}, {26'd0, e.q});
        check({tag, "_hold_r"}, {29'd0, remainder}, {29'd0, e.r});
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_post_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_post_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_quotient", {26'd0, quotient}, 32'd0);
    check("rst_remainder", {29'd0, remainder}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    check("rst_chk", {31'd0, chk_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    $display("[TB] basic operations");
    applyStimulus(6'd49, 3'd7);
    checkOutput("d49_7", 0);
    applyStimulus(6'd63, 3'd5);
    checkOutput("d63_5", 0);
    applyStimulus(6'd0, 3'd1);
    checkOutput("d0_1", 0);
    applyStimulus(6'd63, 3'd1);
    checkOutput("d63_1", 0);

    $display("[TB] divide by zero");
    applyStimulus(6'd10, 3'd0);
    checkOutput("d10_0", 0);

    $display("[TB] backpressure");
    applyStimulus(6'd20, 3'd3);
    checkOutput("bp20_3", 5);

    $display("[TB] in_valid during CALC");
    applyStimulus(6'd20, 3'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("calc_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b1;
      dividend = 6'd7;
      divisor  = 3'd2;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("ign20_3", 0);

    $display("[TB] reset mid-operation");
    applyStimulus(6'd49, 3'd7);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_quotient", {26'd0, quotient}, 32'd0);
    check("abort_remainder", {29'd0, remainder}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    applyStimulus(6'd14, 3'd3);
    checkOutput("d14_3", 0);

    $display("[TB] exhaustive sweep");
    for (int d = 1; d < 8; d++) begin
      for (int n = 0; n < 64; n++) begin
        applyStimulus(6'(n), 3'(d));
        checkOutput("sweep", 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider_3x3.md
Name: seq_divider_3x3

Overview:
- Iterative restoring divider; the inverse operation of the team's 3x3 array multiplier.
- Takes a 2*WIDTH-bit dividend (the product domain) and a WIDTH-bit divisor, and returns a 2*WIDTH-bit quotient and a WIDTH-bit remainder.
- Computes one quotient bit per clock.
- Sits behind the multiplier datapath for reverse/check operations.
- Uses valid/ready handshakes on both input and output.

Parameters:
- WIDTH, 3, divisor and remainder width. Dividend and quotient are 2*WIDTH bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  dividend/divisor are valid.
- in_ready  output  1  block can accept an operation.
- dividend  input  2*WIDTH  numerator, unsigned.
- divisor  input  WIDTH  denominator, unsigned.
- out_valid  output  1  result is valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- quotient  output  2*WIDTH  unsigned quotient.
- remainder  output  WIDTH  unsigned remainder.
- div_by_zero  output  1  the result came from a zero divisor.
- chk_err  output  1  self-check mismatch (see Optional Feature).

Behaviour:
- Reset is asynchronous, active-low: one clock, async active-low reset. While rst_n=0:
  - state=IDLE; in_ready=1 after release.
  - out_valid=0, quotient=0, remainder=0, div_by_zero=0, chk_err=0.
  - Internal counter and partial remainder cleared.
- Reset mid-operation aborts the operation; no result is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept on the edge where in_valid&&in_ready (edge E0); latch dividend and divisor.
  - If divisor!=0: go to CALC with count=2*WIDTH and partial remainder=0.
  - If divisor==0: go directly to DONE with quotient=all ones, remainder=dividend[WIDTH-1:0], div_by_zero=1.
- CALC:
  - in_ready=0; in_valid is ignored.
  - Each edge: the partial remainder (WIDTH+1 bits) shifts left and takes in the next dividend bit, MSB first.
  - If partial >= divisor: subtract the divisor and set the quotient bit to 1; otherwise the quotient bit is 0.
  - count decrements each edge.
  - After the edge where count reaches 0 (edge E0+2*WIDTH): state=DONE and out_valid=1.
- Latency: out_valid is high 2*WIDTH cycles after acceptance (6 for WIDTH=3), or 1 cycle for divide-by-zero.
- DONE:
  - out_valid=1; quotient, remainder and div_by_zero are stable.
  - On an edge with out_ready=1: transfer, go to IDLE, out_valid=0, in_ready=1 on the next cycle.
  - out_ready low: hold indefinitely with outputs unchanged.
  - No input acceptance in the same cycle as output transfer; minimum issue interval is 2*WIDTH+2 cycles.
- Outputs quotient/remainder/div_by_zero keep their last values in IDLE. They are valid only when out_valid=1.
- Arithmetic invariants, for divisor!=0:
  - quotient*divisor + remainder == dividend.
  - remainder < divisor.
- The partial remainder never exceeds WIDTH+1 bits. The final remainder fits in WIDTH bits.

Optional Feature:
- Macro: MULT_CHECK_EN.
- Defined:
  - On entry to DONE with divisor!=0, compute quotient*divisor+remainder combinationally (2*WIDTH-bit compare) against the latched dividend.
  - chk_err=1 in DONE on mismatch, else 0.
  - chk_err is cleared on transfer.
  - Timing and all other outputs are unchanged.
- Not defined: chk_err is tied to 0 and no check logic is built.
- The port exists in both builds.

Test Plan (WIDTH=3):
1. Dividend=49, divisor=7, out_ready=1 -> after 6 cycles out_valid=1, quotient=7, remainder=0, div_by_zero=0; in_ready=1 the cycle after transfer.
2. Dividend=63, divisor=5 -> quotient=12, remainder=3. Dividend=0, divisor=1 -> 0,0. Dividend=63, divisor=1 -> 63,0. Exhaustive sweep of all 64x7 non-zero cases against the reference model, including chk_err=0 with MULT_CHECK_EN.
3. Dividend=10, divisor=0 -> out_valid one cycle after accept, quotient=63, remainder=2, div_by_zero=1.
4. Backpressure: dividend=20, divisor=3, out_ready=0 for 5 cycles after out_valid -> outputs held at q=6, r=2, in_ready=0 throughout; transfer on the first out_ready=1 edge.
5. in_valid pulsed during CALC with other operands -> ignored; the original result is delivered unchanged.
6. rst_n asserted at the 3rd CALC cycle -> out_valid, quotient and remainder go to 0 immediately (asynchronously); after release in_ready=1 and the next operation (14/3 -> q=4, r=2) is correct.
